// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: load-use and RAW
// interlocks, EX-stage operand bypass selects, and mul/div sequencing.
module hazard_ctrl #(
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned MD_CYCLES = 32,
  parameter bit          FWD_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic                id_rs_used,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_rt_used,
  input  logic [REG_BITS-1:0] id_dest,
  input  logic                id_wr,
  input  logic                id_is_load,
  input  logic                id_is_md,
  input  logic                id_reads_hilo,
  input  logic                branch_taken,
  output logic                stall_if_id,
  output logic                clear_if_id,
  output logic                clear_id_ex,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                md_busy,
  output logic                md_done
);

  localparam int unsigned CntW = $clog2(MD_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(MD_CYCLES - 1);

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic                load;
    logic [REG_BITS-1:0] dest;
  } slot_t;

  slot_t ex_q, ex_d, mem_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CntW-1:0] md_cnt_q, md_cnt_d;
  logic md_busy_q, md_busy_d;

  // Register 0 is hardwired, so it never matches an in-flight writer.
  function automatic logic hit(input logic [REG_BITS-1:0] r, input logic used,
                               input slot_t s);
    return s.valid & s.wr & (s.dest == r) & (r != '0) & used;
  endfunction

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, raw_nofwd, md_block, stall_int, adv, md_start;

  assign rs_ex  = hit(id_rs, id_rs_used, ex_q);
  assign rt_ex  = hit(id_rt, id_rt_used, ex_q);
  assign rs_mem = hit(id_rs, id_rs_used, mem_q);
  assign rt_mem = hit(id_rt, id_rt_used, mem_q);

  assign load_use  = (rs_ex | rt_ex) & ex_q.load;
  assign raw_nofwd = !FWD_EN & (rs_ex | rt_ex | rs_mem | rt_mem);
  assign md_block  = (id_reads_hilo | id_is_md) & md_busy_q;
  assign stall_int = id_valid & (load_use | raw_nofwd | md_block);
  assign adv       = id_valid & ~stall_int & ~branch_taken;
  assign md_start  = id_is_md & adv;

  // Branch flush wins over stall: the stalled instruction is being discarded.
  assign stall_if_id = stall_int & ~branch_taken;
  assign clear_if_id = branch_taken;
  assign clear_id_ex = stall_int | branch_taken;

  assign fwd_a   = fwd_a_q;
  assign fwd_b   = fwd_b_q;
  assign md_busy = md_busy_q;
  assign md_done = md_busy_q & (md_cnt_q == '0);

  // Next EX slot and bypass selects for the instruction entering EX.
  always_comb begin
    ex_d    = '0;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (adv) begin
      ex_d.valid = 1'b1;
      ex_d.wr    = id_wr;
      ex_d.load  = id_is_load;
      ex_d.dest  = id_dest;
      if (FWD_EN) begin
        // EX holds the most recent writer, so it takes priority over MEM.
        if (rs_ex && !ex_q.load) fwd_a_d = 2'b01;
        else if (rs_mem)         fwd_a_d = 2'b10;
        if (rt_ex && !ex_q.load) fwd_b_d = 2'b01;
        else if (rt_mem)         fwd_b_d = 2'b10;
      end
    end
  end

  // Mul/div countdown; a branch flush never aborts a running operation.
  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_busy_d = md_busy_q;
    if (md_start) begin
      md_cnt_d  = CntLoad;
      md_busy_d = 1'b1;
    end else if (md_busy_q) begin
      if (md_cnt_q == '0) md_busy_d = 1'b0;
      else                md_cnt_d  = md_cnt_q - 1'b1;
    end
  end

  // Scoreboard shift and registered forwarding selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Mul/div state; reset aborts an operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q  <= '0;
      md_busy_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instance 0 bypasses, instance 1 is stall-only.
module tb_hazard_ctrl;

  localparam int MD = 4;

  typedef struct {
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       md;
    logic       hilo;
  } instr_t;

  logic clk, rst;
  logic       id_valid [2];
  logic [4:0] id_rs [2];
  logic       id_rs_used [2];
  logic [4:0] id_rt [2];
  logic       id_rt_used [2];
  logic [4:0] id_dest [2];
  logic       id_wr [2];
  logic       id_is_load [2];
  logic       id_is_md [2];
  logic       id_reads_hilo [2];
  logic       branch_taken [2];
  logic       stall_if_id [2];
  logic       clear_if_id [2];
  logic       clear_id_ex [2];
  logic [1:0] fwd_a [2];
  logic [1:0] fwd_b [2];
  logic       md_busy [2];
  logic       md_done [2];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_ctrl #(.REG_BITS(5), .MD_CYCLES(MD), .FWD_EN(g == 0)) u_dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid[g]), .id_rs(id_rs[g]), .id_rs_used(id_rs_used[g]),
      .id_rt(id_rt[g]), .id_rt_used(id_rt_used[g]), .id_dest(id_dest[g]),
      .id_wr(id_wr[g]), .id_is_load(id_is_load[g]), .id_is_md(id_is_md[g]),
      .id_reads_hilo(id_reads_hilo[g]), .branch_taken(branch_taken[g]),
      .stall_if_id(stall_if_id[g]), .clear_if_id(clear_if_id[g]),
      .clear_id_ex(clear_id_ex[g]), .fwd_a(fwd_a[g]), .fwd_b(fwd_b[g]),
      .md_busy(md_busy[g]), .md_done(md_done[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- Behavioural model ----------------
  // Instructions in flight by age beyond ID (1 = EX, 2 = MEM).
  logic       m_v  [2][3];
  logic       m_w  [2][3];
  logic       m_ld [2][3];
  logic [4:0] m_d  [2][3];
  int         m_rem [2];      // busy cycles still to go
  logic [1:0] m_fa [2];
  logic [1:0] m_fb [2];
  logic       m_adv_last [2];

  // Age of the youngest in-flight writer of r, 0 if none.
  function automatic int src_age(input int g, input logic [4:0] r, input logic used);
    if (!used || r == 5'd0) return 0;
    for (int a = 1; a <= 2; a++)
      if (m_v[g][a] && m_w[g][a] && m_d[g][a] == r) return a;
    return 0;
  endfunction

  function automatic logic m_stall(input int g);
    int aa, ab;
    if (!id_valid[g]) return 1'b0;
    aa = src_age(g, id_rs[g], id_rs_used[g]);
    ab = src_age(g, id_rt[g], id_rt_used[g]);
    if ((aa == 1 || ab == 1) && m_ld[g][1]) return 1'b1;
    if (g == 1 && (aa != 0 || ab != 0)) return 1'b1;
    if ((id_reads_hilo[g] || id_is_md[g]) && m_rem[g] > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_adv(input int g);
    return id_valid[g] && !m_stall(g) && !branch_taken[g];
  endfunction

  function automatic logic [1:0] m_fwd(input int g, input logic [4:0] r, input logic used);
    int a;
    if (g == 1) return 2'b00;
    a = src_age(g, r, used);
    return (a == 1) ? 2'b01 : (a == 2) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        for (int a = 0; a < 3; a++) begin
          m_v[g][a] <= 1'b0; m_w[g][a] <= 1'b0; m_ld[g][a] <= 1'b0; m_d[g][a] <= 5'd0;
        end
        m_rem[g] <= 0; m_fa[g] <= 2'b00; m_fb[g] <= 2'b00; m_adv_last[g] <= 1'b0;
      end else begin
        m_v[g][2] <= m_v[g][1]; m_w[g][2] <= m_w[g][1];
        m_ld[g][2] <= m_ld[g][1]; m_d[g][2] <= m_d[g][1];
        m_v[g][1] <= m_adv(g); m_w[g][1] <= id_wr[g];
        m_ld[g][1] <= id_is_load[g]; m_d[g][1] <= id_dest[g];
        m_fa[g] <= m_adv(g) ? m_fwd(g, id_rs[g], id_rs_used[g]) : 2'b00;
        m_fb[g] <= m_adv(g) ? m_fwd(g, id_rt[g], id_rt_used[g]) : 2'b00;
        if (m_adv(g) && id_is_md[g]) m_rem[g] <= MD;
        else if (m_rem[g] > 0)       m_rem[g] <= m_rem[g] - 1;
        m_adv_last[g] <= m_adv(g);
      end
    end
  end

  task automatic check(input string nm, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      check("stall_if_id", g, 32'(stall_if_id[g]), 32'(m_stall(g) && !branch_taken[g]));
      check("clear_if_id", g, 32'(clear_if_id[g]), 32'(branch_taken[g]));
      check("clear_id_ex", g, 32'(clear_id_ex[g]), 32'(m_stall(g) || branch_taken[g]));
      check("fwd_a", g, 32'(fwd_a[g]), 32'(m_fa[g]));
      check("fwd_b", g, 32'(fwd_b[g]), 32'(m_fb[g]));
      check("md_busy", g, 32'(md_busy[g]), 32'(m_rem[g] > 0));
      check("md_done", g, 32'(md_done[g]), 32'(m_rem[g] == 1));
    end
    if (md_done[0]) done_cnt++;
  end

  // ---------------- Stimulus ----------------
  function automatic instr_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t i = '{rs: s, rsu: 1'b1, rt: t, rtu: 1'b1, dst: d, wr: 1'b1,
                  ld: 1'b0, md: 1'b0, hilo: 1'b0};
    return i;
  endfunction

  function automatic instr_t lw(input logic [4:0] d, input logic [4:0] b);
    instr_t i = '{rs: b, rsu: 1'b1, rt: d, rtu: 1'b0, dst: d, wr: 1'b1,
                  ld: 1'b1, md: 1'b0, hilo: 1'b0};
    return i;
  endfunction

  function automatic instr_t mult(input logic [4:0] s, input logic [4:0] t);
    instr_t i = '{rs: s, rsu: 1'b1, rt: t, rtu: 1'b1, dst: 5'd0, wr: 1'b0,
                  ld: 1'b0, md: 1'b1, hilo: 1'b0};
    return i;
  endfunction

  function automatic instr_t mflo(input logic [4:0] d);
    instr_t i = '{rs: 5'd0, rsu: 1'b0, rt: 5'd0, rtu: 1'b0, dst: d, wr: 1'b1,
                  ld: 1'b0, md: 1'b0, hilo: 1'b1};
    return i;
  endfunction

  task automatic drive(input int g, input logic v, input instr_t in, input logic br);
    id_valid[g] = v; id_rs[g] = in.rs; id_rs_used[g] = in.rsu;
    id_rt[g] = in.rt; id_rt_used[g] = in.rtu; id_dest[g] = in.dst;
    id_wr[g] = in.wr; id_is_load[g] = in.ld; id_is_md[g] = in.md;
    id_reads_hilo[g] = in.hilo; branch_taken[g] = br;
  endtask

  task automatic idle(input int n);
    instr_t z = alu(5'd0, 5'd0, 5'd0);
    drive(0, 1'b0, z, 1'b0);
    drive(1, 1'b0, z, 1'b0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Hold an instruction in ID until it advances; n = cycles it was presented.
  task automatic issue(input int g, input instr_t in, output int n);
    n = 0;
    drive(g, 1'b1, in, 1'b0);
    do begin
      @(posedge clk); #1; n++;
    end while (!m_adv_last[g] && n < 20);
    if (!m_adv_last[g]) begin
      checks++; errors++;
      $display("FAIL issue_timeout[%0d]: instruction never advanced within %0d cycles", g, n);
    end
    drive(g, 1'b0, in, 1'b0);
  endtask

  initial begin
    int n, base;
    rst = 1'b1;
    idle(0);
    #2;
    check("rst_fwd_a", 0, 32'(fwd_a[0]), 0);
    check("rst_md_busy", 0, 32'(md_busy[0]), 0);
    check("rst_stall", 0, 32'(stall_if_id[0]), 0);
    check("rst_clear_id_ex", 1, 32'(clear_id_ex[1]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // EX-to-EX bypass on both operands
    issue(0, alu(5'd3, 5'd1, 5'd2), n);
    issue(0, alu(5'd4, 5'd3, 5'd3), n);
    check("raw_ex_cycles", 0, n, 1);
    check("raw_ex_fwd_a", 0, 32'(fwd_a[0]), 32'h1);
    check("raw_ex_fwd_b", 0, 32'(fwd_b[0]), 32'h1);
    idle(3);

    // MEM bypass across one independent instruction
    issue(0, alu(5'd3, 5'd1, 5'd2), n);
    issue(0, alu(5'd9, 5'd1, 5'd2), n);
    issue(0, alu(5'd10, 5'd3, 5'd1), n);
    check("raw_mem_cycles", 0, n, 1);
    check("raw_mem_fwd_a", 0, 32'(fwd_a[0]), 32'h2);
    check("raw_mem_fwd_b", 0, 32'(fwd_b[0]), 32'h0);
    idle(3);

    // Load-use: one stall cycle, then MEM bypass
    issue(0, lw(5'd5, 5'd1), n);
    issue(0, alu(5'd6, 5'd5, 5'd0), n);
    check("load_use_cycles", 0, n, 2);
    check("load_use_fwd_a", 0, 32'(fwd_a[0]), 32'h2);
    check("load_use_fwd_b", 0, 32'(fwd_b[0]), 32'h0);
    idle(3);

    // Stall-only instance waits for the writer to reach WB
    issue(1, alu(5'd3, 5'd1, 5'd2), n);
    issue(1, alu(5'd7, 5'd3, 5'd2), n);
    check("nofwd_cycles", 1, n, 3);
    check("nofwd_fwd_a", 1, 32'(fwd_a[1]), 32'h0);
    idle(3);

    // Register 0 never hazards
    issue(0, lw(5'd0, 5'd1), n);
    issue(0, alu(5'd8, 5'd0, 5'd0), n);
    check("r0_cycles", 0, n, 1);
    check("r0_fwd_a", 0, 32'(fwd_a[0]), 32'h0);
    check("r0_fwd_b", 0, 32'(fwd_b[0]), 32'h0);
    idle(3);

    // mult then mflo: four busy cycles, one done pulse
    base = done_cnt;
    issue(0, mult(5'd1, 5'd2), n);
    check("md_busy_start", 0, 32'(md_busy[0]), 1);
    issue(0, mflo(5'd11), n);
    check("mflo_cycles", 0, n, 5);
    check("md_done_pulses", 0, done_cnt - base, 1);
    check("md_busy_end", 0, 32'(md_busy[0]), 0);
    idle(2);

    // Back-to-back mult waits the same way
    issue(0, mult(5'd1, 5'd2), n);
    issue(0, mult(5'd3, 5'd4), n);
    check("mult2_cycles", 0, n, 5);
    idle(6);

    // Branch together with a load-use stall
    issue(0, lw(5'd5, 5'd1), n);
    drive(0, 1'b1, alu(5'd6, 5'd5, 5'd0), 1'b1);
    #1;
    check("br_clear_if_id", 0, 32'(clear_if_id[0]), 1);
    check("br_clear_id_ex", 0, 32'(clear_id_ex[0]), 1);
    check("br_stall_if_id", 0, 32'(stall_if_id[0]), 0);
    @(posedge clk); #1;
    idle(3);

    // Branch blocks an md start
    drive(0, 1'b1, mult(5'd1, 5'd2), 1'b1);
    @(posedge clk); #1;
    check("br_md_blocked", 0, 32'(md_busy[0]), 0);
    idle(3);

    // Reset mid operation aborts without a done pulse
    issue(0, mult(5'd1, 5'd2), n);
    idle(2);
    base = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 0, 32'(md_busy[0]), 0);
    check("rst_mid_done", 0, 32'(md_done[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    check("rst_mid_no_pulse", 0, done_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the IF/ID hold/clear and ID/EX clear inputs of the pipeline registers, and the EX-stage operand forwarding selects.
- Tracks in-flight destination registers in an internal scoreboard.
- Sequences a multi-cycle mul/div unit: busy counter, HI/LO interlock.
- Parametrised in register-address width, mul/div latency and forwarding mode (full bypass or stall-only).

Parameters:
- REG_BITS, 5, register address width.
- MD_CYCLES, 32, mul/div latency in cycles; legal range is 2 or more.
- FWD_EN, 1, forwarding mode: 1 = bypass from EX/MEM and MEM/WB; 0 = no bypass, stall until the writer reaches WB.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_BITS  ID source register 1.
- id_rs_used  in  1  instruction reads id_rs.
- id_rt  in  REG_BITS  ID source register 2.
- id_rt_used  in  1  instruction reads id_rt.
- id_dest  in  REG_BITS  ID destination register (already muxed rt/rd).
- id_wr  in  1  instruction writes id_dest.
- id_is_load  in  1  instruction is a load.
- id_is_md  in  1  instruction starts mul/div.
- id_reads_hilo  in  1  instruction is mfhi/mflo.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- stall_if_id  out  1  hold PC and IF/ID.
- clear_if_id  out  1  flush IF/ID.
- clear_id_ex  out  1  insert a bubble into ID/EX.
- fwd_a  out  2  EX operand A select: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- fwd_b  out  2  EX operand B select, same encoding.
- md_busy  out  1  mul/div unit is computing.
- md_done  out  1  one-cycle pulse when the result is written to HI/LO.

Behaviour:
- Scoreboard: two slots, EX and MEM, each holding {valid, wr, load, dest}.
  - Every cycle: MEM <= EX.
  - EX <= ID info if `adv`, else a bubble (valid = 0).
  - `adv` = id_valid & !stall_int & !branch_taken.
- Hit definition: match(r, slot) = slot.valid & slot.wr & slot.dest == r & r != 0 & the corresponding _used input is set.
- Register 0 never causes a hazard or a forward.
- Internal stall term `stall_int` (combinational), OR of:
  - Load-use: match(rs or rt, EX) & EX.load.
  - FWD_EN = 0 only: match(rs or rt, EX or MEM).
  - id_reads_hilo & md_busy.
  - id_is_md & md_busy.
  - Every stall term is gated by id_valid.
- Output logic (combinational):
  - stall_if_id = stall_int & !branch_taken.
  - clear_if_id = branch_taken.
  - clear_id_ex = stall_int | branch_taken.
  - Branch flush has priority over stall.
- Forwarding selects are registered. They are computed in ID when `adv` is true and loaded into fwd_a/fwd_b, so they are valid for exactly the cycle the instruction is in EX. Otherwise they load 00.
  - fwd_x = 01 if match(reg, EX) & !EX.load.
  - else 10 if match(reg, MEM).
  - else 00.
  - The EX slot has priority (most recent writer).
  - With FWD_EN = 0, fwd_a and fwd_b are constant 00.
- The register file is write-before-read, so a writer in WB needs no forward.
- Mul/div counter, width clog2(MD_CYCLES):
  - Start condition: id_is_md & `adv`. The counter loads MD_CYCLES-1 and md_busy goes to 1 on the next edge.
  - While busy, the counter decrements each cycle.
  - At count 0 and busy: md_busy goes to 0 and md_done pulses high for one cycle.
  - A branch flush in the same cycle as an md start blocks the start (`adv` = 0).
  - A branch flush while busy does not abort the operation; the unit was started by an older instruction.
- Reset (asynchronous): all scoreboard slots invalid; fwd_a = fwd_b = 00; counter = 0; md_busy = 0; md_done = 0.
  - Combinational outputs follow from the reset state: stall/clear outputs are 0 unless branch_taken is asserted.
  - Reset mid mul/div aborts the operation; no md_done pulse is produced.
- No hazard is ever declared against a bubble or a flushed slot.

Test Plan:
- add $3,$1,$2 then add $4,$3,$3 (FWD_EN=1) -> no stall; fwd_a = fwd_b = 01 in the second instruction's EX cycle. A third instruction reading $3 after one independent instruction -> fwd = 10.
- lw $5,0($1) then add $6,$5,$0 -> stall_if_id = 1 and clear_id_ex = 1 for exactly one cycle; the add then sees fwd_a = 10 and fwd_b = 00.
- FWD_EN=0, add $3,.. then sub $7,$3,$2 -> stall_if_id high for 2 cycles; fwd outputs stay 00.
- Write to $0 followed by a reader of $0 -> no stall, fwd = 00.
- MD_CYCLES=4, mult followed immediately by mflo:
  - md_busy high for 4 cycles.
  - mflo is stalled during those 4 cycles; md_done pulses in the 4th busy cycle.
  - mflo advances in the cycle after md_done.
  - A second mult issued while busy is stalled the same way.
- branch_taken asserted together with a load-use stall -> clear_if_id = 1, clear_id_ex = 1, stall_if_id = 0. Asserting rst mid mul/div -> md_busy = 0 immediately and no md_done pulse.
